// File: rtl/sipo_deserializer.sv
// ----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-to-parallel receive stage that sits directly downstream of a PISO
// shift register. One serial bit is sampled per enabled clock, MSB first, and
// WIDTH-bit words are assembled. Word alignment comes from an explicit sync
// strobe: the bit qualified by enable & sync is the MSB of a new word. Each
// completed word is presented on a valid/ready output. A sticky overrun flag
// records any completed word that had to be dropped because the previous word
// had not yet been consumed.
//
// Ports:
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous active-high reset
//   enable         in   1      bit strobe; serial_in is sampled on this edge
//   sync           in   1      word boundary; qualified bit is the new word's MSB
//   serial_in      in   1      serial data, MSB first
//   data_out       out  WIDTH  assembled word, stable while data_valid=1
//   data_valid     out  1      word available
//   data_ready     in   1      consumer accepts when data_valid & data_ready
//   overrun        out  1      sticky: a completed word was dropped
//   clear_overrun  in   1      synchronous clear of overrun
//   bit_count      out  CNT_W  bits collected in the current partial word
//   hunting        out  1      1 while no word alignment has been seen
// ----------------------------------------------------------------------------
module sipo_deserializer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic [CNT_W-1:0] bit_count,
    output logic             hunting
);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    // Only the WIDTH-1 most recent bits need storing: the final bit of a word
    // is taken straight from serial_in on the completion edge.
    logic [WIDTH-2:0]   r_shreg;
    logic [CNT_W-1:0]   r_bit_count;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;
    logic               r_overrun;
    logic               r_hunting;

    logic [WIDTH-1:0]   w_candidate;
    logic               w_word_done;
    logic               w_overrun_set;

    // The word that would exist if this edge's bit were appended.
    assign w_candidate   = {r_shreg, serial_in};

    // A sync-qualified bit always starts a new word, so it can never complete one.
    assign w_word_done   = enable && !sync && (r_state == SHIFT) && (r_bit_count == LAST_BIT);

    // Completed word arrives while the held one is still unconsumed: drop it.
    assign w_overrun_set = w_word_done && r_data_valid && !data_ready;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_shreg      <= '0;
            r_bit_count  <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_hunting    <= 1'b1;
        end else begin
            // Bit collection and alignment.
            if (enable) begin
                if (sync) begin
                    // Any partial word is discarded; this bit is the new MSB.
                    r_state     <= SHIFT;
                    r_hunting   <= 1'b0;
                    r_shreg     <= (WIDTH-1)'(serial_in);
                    r_bit_count <= CNT_W'(1);
                end else if (r_state == SHIFT) begin
                    if (w_word_done) begin
                        r_shreg     <= '0;
                        r_bit_count <= '0;
                    end else begin
                        r_shreg     <= w_candidate[WIDTH-2:0];
                        r_bit_count <= r_bit_count + CNT_W'(1);
                    end
                end
            end

            // Output handshake. A completion with the slot free or being
            // emptied this edge loads the new word with no bubble in valid.
            if (w_word_done) begin
                if (!r_data_valid || data_ready) begin
                    r_data_out   <= w_candidate;
                    r_data_valid <= 1'b1;
                end
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            // Set takes priority over a simultaneous clear.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;
    assign bit_count  = r_bit_count;
    assign hunting    = r_hunting;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Self-checking bench for sipo_deserializer (WIDTH=8). Directed scenarios
// cover reset, basic assembly, hunting, overrun, back-to-back delivery,
// re-synchronisation and a PISO loopback with async reset mid-word. A random
// phase compares every output each cycle against a word-level reference model
// built from integer accumulation of received bits.
// ----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sync;
    logic          serial_in;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          data_ready;
    logic          overrun;
    logic          clear_overrun;
    logic [CW-1:0] bit_count;
    logic          hunting;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: alignment flag, bits gathered, integer value so far,
    // and the expected output slot.
    bit m_aligned;
    int m_n;
    int m_acc;
    int m_data;
    bit m_valid;
    bit m_ovr;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sync          (sync),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .bit_count     (bit_count),
        .hunting       (hunting)
    );

    task automatic model_reset;
        m_aligned = 0; m_n = 0; m_acc = 0; m_data = 0; m_valid = 0; m_ovr = 0;
    endtask

    // Drive one cycle of inputs, advance past the rising edge, update the model,
    // and leave time at posedge+1 so outputs are sampled away from the edge.
    task automatic tick(input logic en, input logic sy, input logic sb,
                        input logic rdy, input logic clr);
        bit done;
        bit set;
        int word;
        enable = en; sync = sy; serial_in = sb; data_ready = rdy; clear_overrun = clr;
        @(posedge clk);
        done = 0;
        word = 0;
        if (en) begin
            if (sy) begin
                m_acc = int'(sb); m_n = 1; m_aligned = 1;
            end else if (m_aligned) begin
                m_acc = m_acc * 2 + int'(sb);
                m_n++;
                if (m_n == W) begin
                    done = 1; word = m_acc; m_acc = 0; m_n = 0;
                end
            end
        end
        set = done && m_valid && !rdy;
        if (done) begin
            if (!m_valid || rdy) begin
                m_data = word; m_valid = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (set) m_ovr = 1;
        else if (clr) m_ovr = 0;
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic sync_first,
                             input logic rdy, input logic clr);
        for (int i = W - 1; i >= 0; i--) begin
            tick(1'b1, sync_first && (i == W - 1), word[i], rdy, clr);
        end
    endtask

    task automatic apply_reset;
        enable = 0; sync = 0; serial_in = 0; data_ready = 0; clear_overrun = 0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset;
        apply_reset();
        n_total++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (bit_count !== '0) $display("FAIL reset_bit_count: got %0d want 0", bit_count); else n_pass++;
        n_total++; if (hunting !== 1'b1) $display("FAIL reset_hunting: got %b want 1", hunting); else n_pass++;
    endtask

    task automatic test_basic;
        logic [W-1:0] w;
        apply_reset();
        w = 8'hA5;
        for (int i = W - 1; i >= 1; i--) begin
            tick(1'b1, i == W - 1, w[i], 1'b1, 1'b0);
            n_total++;
            if (bit_count !== CW'(W - i))
                $display("FAIL basic_bit_count: got %0d want %0d", bit_count, W - i);
            else n_pass++;
            n_total++; if (hunting !== 1'b0) $display("FAIL basic_hunting: got %b want 0", hunting); else n_pass++;
            n_total++; if (data_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", data_valid); else n_pass++;
        end
        tick(1'b1, 1'b0, w[0], 1'b1, 1'b0);
        n_total++; if (data_out !== 8'hA5) $display("FAIL basic_data: got %h want a5", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", data_valid); else n_pass++;
        n_total++; if (bit_count !== '0) $display("FAIL basic_count_wrap: got %0d want 0", bit_count); else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (data_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", data_valid); else n_pass++;
        n_total++; if (data_out !== 8'hA5) $display("FAIL basic_data_hold: got %h want a5", data_out); else n_pass++;
    endtask

    task automatic test_no_sync;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
            n_total++; if (hunting !== 1'b1) $display("FAIL nosync_hunting: got %b want 1", hunting); else n_pass++;
            n_total++; if (bit_count !== '0) $display("FAIL nosync_bit_count: got %0d want 0", bit_count); else n_pass++;
            n_total++; if (data_valid !== 1'b0) $display("FAIL nosync_valid: got %b want 0", data_valid); else n_pass++;
        end
        // sync without enable must not align either
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_total++; if (hunting !== 1'b1) $display("FAIL sync_no_enable_hunting: got %b want 1", hunting); else n_pass++;
    endtask

    task automatic test_overrun;
        apply_reset();
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        n_total++; if (data_out !== 8'h3C) $display("FAIL ovr_first_data: got %h want 3c", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b1) $display("FAIL ovr_first_valid: got %b want 1", data_valid); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL ovr_premature: got %b want 0", overrun); else n_pass++;
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        n_total++; if (data_out !== 8'h3C) $display("FAIL ovr_data_held: got %h want 3c", data_out); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else n_pass++;
        n_total++; if (data_valid !== 1'b1) $display("FAIL ovr_valid_kept: got %b want 1", data_valid); else n_pass++;
        // clear held high across a dropping completion: set wins
        send_word(8'h55, 1'b0, 1'b0, 1'b1);
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b want 1", overrun); else n_pass++;
        n_total++; if (data_out !== 8'h3C) $display("FAIL ovr_data_held2: got %h want 3c", data_out); else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (data_valid !== 1'b0) $display("FAIL ovr_consume: got %b want 0", data_valid); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w;
        apply_reset();
        send_word(8'h01, 1'b1, 1'b1, 1'b0);
        n_total++; if (data_out !== 8'h01) $display("FAIL b2b_first: got %h want 01", data_out); else n_pass++;
        send_word(8'h80, 1'b0, 1'b1, 1'b0);
        n_total++; if (data_out !== 8'h80) $display("FAIL b2b_second: got %h want 80", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b want 1", data_valid); else n_pass++;
        // hold ready low until the completion edge: word handed off with valid kept high
        w = 8'h7E;
        for (int i = W - 1; i >= 1; i--) tick(1'b1, 1'b0, w[i], 1'b0, 1'b0);
        n_total++; if (data_out !== 8'h80) $display("FAIL b2b_pre_handoff: got %h want 80", data_out); else n_pass++;
        tick(1'b1, 1'b0, w[0], 1'b1, 1'b0);
        n_total++; if (data_valid !== 1'b1) $display("FAIL b2b_handoff_valid: got %b want 1", data_valid); else n_pass++;
        n_total++; if (data_out !== 8'h7E) $display("FAIL b2b_handoff_data: got %h want 7e", data_out); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_resync;
        apply_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if (bit_count !== CW'(5)) $display("FAIL resync_partial: got %0d want 5", bit_count); else n_pass++;
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_total++; if (bit_count !== CW'(1)) $display("FAIL resync_restart: got %0d want 1", bit_count); else n_pass++;
        send_word(8'hF0, 1'b1, 1'b1, 1'b0);
        n_total++; if (data_out !== 8'hF0) $display("FAIL resync_data: got %h want f0", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b1) $display("FAIL resync_valid: got %b want 1", data_valid); else n_pass++;
    endtask

    task automatic test_loopback;
        logic [W-1:0] piso;
        apply_reset();
        piso = 8'h5A;
        for (int i = 0; i < W; i++) begin
            tick(1'b1, i == 0, piso[W-1], 1'b0, 1'b0);
            piso = {piso[W-2:0], 1'b0};
        end
        n_total++; if (data_out !== 8'h5A) $display("FAIL loop_data: got %h want 5a", data_out); else n_pass++;
        // start another word, then reset asynchronously mid-cycle
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_total++; if (data_out !== 8'h00) $display("FAIL arst_data: got %h want 00", data_out); else n_pass++;
        n_total++; if (data_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", data_valid); else n_pass++;
        n_total++; if (bit_count !== '0) $display("FAIL arst_bit_count: got %0d want 0", bit_count); else n_pass++;
        n_total++; if (hunting !== 1'b1) $display("FAIL arst_hunting: got %b want 1", hunting); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL arst_overrun: got %b want 0", overrun); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(99) < 75), 1'($urandom_range(99) < 8),
                 1'($urandom_range(1)), 1'($urandom_range(99) < 50),
                 1'($urandom_range(99) < 5));
            n_total++;
            if (data_valid !== m_valid) $display("FAIL rand_valid @%0d: got %b want %b", i, data_valid, m_valid); else n_pass++;
            n_total++;
            if (data_out !== W'(m_data)) $display("FAIL rand_data @%0d: got %h want %h", i, data_out, W'(m_data)); else n_pass++;
            n_total++;
            if (overrun !== m_ovr) $display("FAIL rand_overrun @%0d: got %b want %b", i, overrun, m_ovr); else n_pass++;
            n_total++;
            if (bit_count !== CW'(m_n)) $display("FAIL rand_bit_count @%0d: got %0d want %0d", i, bit_count, m_n); else n_pass++;
            n_total++;
            if (hunting !== !m_aligned) $display("FAIL rand_hunting @%0d: got %b want %b", i, hunting, !m_aligned); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 0; sync = 0; serial_in = 0; data_ready = 0; clear_overrun = 0;
        model_reset();
        test_reset();
        test_basic();
        test_no_sync();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_loopback();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
